// File: rtl/gate_sweep_pkg.sv
// ============================================================================
// Module      : gate_sweep_pkg
// Description : Shared state encoding, vector count and truth-table constants
//               for the gate sweep controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned NUM_VEC  = 4;
    localparam logic [1:0]  LAST_VEC = 2'(NUM_VEC - 1);
    localparam int unsigned CNT_W    = 4;

    // Truth tables indexed by {a,b}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    function automatic logic [3:0] tt_set_bit(input logic [3:0] tt,
                                              input logic [1:0] idx,
                                              input logic       y);
        logic [3:0] r;
        r      = tt;
        r[idx] = y;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
// ============================================================================
// Module      : gate_sweep_ctrl
// Description : Sweeps the four {a,b} vectors through a 2-input gate, captures
//               its truth table and compares it with EXP_TT. Optional failure
//               counter enabled by macro GATE_SWEEP_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [3:0]  EXP_TT     = TT_NAND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_drv,
    output logic       b_drv,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] truth_tbl,
    output logic [1:0] vec_idx
`ifdef GATE_SWEEP_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_vec;
    logic [1:0]       w_vec_nxt;
    logic             r_a;
    logic             w_a_nxt;
    logic             r_b;
    logic             w_b_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_pass;
    logic             w_pass_nxt;
    logic [3:0]       r_tt;
    logic [3:0]       w_tt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_tt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vec   <= w_vec_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_busy  <= w_busy_nxt;
            r_pass  <= w_pass_nxt;
            r_tt    <= w_tt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vec_nxt   = r_vec;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_busy_nxt  = r_busy;
        w_pass_nxt  = r_pass;
        w_tt_nxt    = r_tt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_vec_nxt   = '0;
                    w_a_nxt     = 1'b0;
                    w_b_nxt     = 1'b0;
                    w_tt_nxt    = '0;
                    w_pass_nxt  = 1'b0;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_tt_nxt = tt_set_bit(r_tt, r_vec, y_in);
                if (r_vec == LAST_VEC) begin
                    w_pass_nxt  = (w_tt_nxt == EXP_TT);
                    w_a_nxt     = 1'b0;
                    w_b_nxt     = 1'b0;
                    w_state_nxt = ST_DONE;
                end else begin
                    // Drives track the index so a/b never disagree with vec_idx
                    w_vec_nxt          = r_vec + 2'd1;
                    {w_a_nxt, w_b_nxt} = r_vec + 2'd1;
                    w_cnt_nxt          = c_CNT_LOAD;
                    w_state_nxt        = ST_SETTLE;
                end
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef GATE_SWEEP_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts failing sweeps; start never clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if ((r_state == ST_DONE) && !r_pass && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign a_drv     = r_a;
    assign b_drv     = r_b;
    assign busy      = r_busy;
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign truth_tbl = r_tt;
    assign vec_idx   = r_vec;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
// ============================================================================
// Module      : tb_gate_sweep_ctrl
// Description : Self-checking bench for gate_sweep_ctrl: two instances
//               (default NAND/2-cycle settle, NOR/1-cycle settle) driven by
//               a behavioural gate model with random truth tables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] tt;
        logic [1:0] vec;
        logic [7:0] err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1, y0, y1;
    logic a0, b0, busy0, done0, pass0;
    logic a1, b1, busy1, done1, pass1;
    logic [3:0] tt0, tt1;
    logic [1:0] vec0, vec1;
`ifdef GATE_SWEEP_ERRCNT_EN
    logic [7:0] err0, err1;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int errm [2];

    always #5 clk = ~clk;

    gate_sweep_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a_drv(a0), .b_drv(b0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0),
        .truth_tbl(tt0), .vec_idx(vec0)
`ifdef GATE_SWEEP_ERRCNT_EN
        , .err_cnt(err0)
`endif
    );

    gate_sweep_ctrl #(.SETTLE_CYC(1), .EXP_TT(TT_NOR)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_drv(a1), .b_drv(b1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .truth_tbl(tt1), .vec_idx(vec1)
`ifdef GATE_SWEEP_ERRCNT_EN
        , .err_cnt(err1)
`endif
    );

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        o.err = '0;
        if (sel == 0) begin
            o.a = a0; o.b = b0; o.busy = busy0; o.done = done0; o.pass = pass0;
            o.tt = tt0; o.vec = vec0;
`ifdef GATE_SWEEP_ERRCNT_EN
            o.err = err0;
`endif
        end else begin
            o.a = a1; o.b = b1; o.busy = busy1; o.done = done1; o.pass = pass1;
            o.tt = tt1; o.vec = vec1;
`ifdef GATE_SWEEP_ERRCNT_EN
            o.err = err1;
`endif
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic y);
        if (sel == 0) begin start0 = st; y0 = y; end
        else          begin start1 = st; y1 = y; end
    endtask

    task automatic chk_all_zero(input string tag);
        obs_t o;
        for (int s = 0; s < 2; s++) begin
            o = get_obs(s);
            chk({tag, "_outs"}, 32'({o.a, o.b, o.busy, o.done, o.pass, o.tt, o.vec}), 32'd0);
`ifdef GATE_SWEEP_ERRCNT_EN
            chk({tag, "_err"}, 32'(o.err), 32'd0);
`endif
        end
    endtask

    // One sweep on instance sel with a gate whose truth table is g.
    // Cycle k counts from 1 = the cycle right after the accept edge.
    // glitch: y_in is wrong except in the last cycle each vector is held.
    // stray:  extra start pulse in cycle 5; hold: start kept high throughout.
    task automatic sweep(input int sel, input logic [3:0] g, input bit glitch,
                         input bit stray, input bit hold);
        int S, L, v;
        logic [3:0] exp_tt, ttexp;
        logic exp_pass, ylast;
        obs_t o;
        S        = (sel == 0) ? 2 : 1;
        ttexp    = (sel == 0) ? TT_NAND : TT_NOR;
        L        = 4 * (S + 1) + 1;
        exp_pass = (g == ttexp);
        @(negedge clk);
        drive(sel, 1'b1, 1'b0);
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            o = get_obs(sel);
            v = (k - 1) / (S + 1);
            if (v > 3) v = 3;
            exp_tt = '0;
            for (int q = 0; q < 4; q++)
                if ((q + 1) * (S + 1) <= k - 1) exp_tt[q] = g[q];
            chk("busy", 32'(o.busy), 32'd1);
            chk("done", 32'(o.done), 32'(k == L));
            chk("vec_idx", 32'(o.vec), 32'(v));
            chk("ab_drv", 32'({o.a, o.b}), (k == L) ? 32'd0 : 32'(v));
            chk("truth_tbl", 32'(o.tt), 32'(exp_tt));
            chk("pass", 32'(o.pass), (k == L) ? 32'(exp_pass) : 32'd0);
            ylast = ((k % (S + 1)) == 0);
            drive(sel, hold || (stray && k == 5),
                  (k < L) ? (g[v] ^ (glitch && !ylast)) : 1'($urandom_range(0, 1)));
        end
        if (!exp_pass && errm[sel] < 255) errm[sel]++;
        @(negedge clk);
        o = get_obs(sel);
        chk("idle_busy", 32'(o.busy), 32'd0);
        chk("idle_done", 32'(o.done), 32'd0);
        chk("idle_pass", 32'(o.pass), 32'(exp_pass));
        chk("idle_tt", 32'(o.tt), 32'(g));
        chk("idle_vec", 32'(o.vec), 32'd3);
`ifdef GATE_SWEEP_ERRCNT_EN
        chk("err_cnt", 32'(o.err), 32'(errm[sel]));
`endif
        if (hold) begin
            @(negedge clk);
            o = get_obs(sel);
            chk("b2b_busy", 32'(o.busy), 32'd1);
            chk("b2b_pass", 32'(o.pass), 32'd0);
            chk("b2b_tt", 32'(o.tt), 32'd0);
            chk("b2b_vec", 32'(o.vec), 32'd0);
            drive(sel, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        obs_t o;
        errm[0] = 0; errm[1] = 0;
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; y0 = 1'b0; y1 = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        sweep(0, TT_NAND, 1'b1, 1'b0, 1'b0);
        sweep(0, TT_AND,  1'b1, 1'b0, 1'b0);
        sweep(1, TT_NOR,  1'b1, 1'b0, 1'b0);
        sweep(1, TT_XOR,  1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            g = 4'($urandom_range(0, 15));
            sweep(i % 2, g, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        sweep(0, TT_NAND, 1'b1, 1'b1, 1'b0);
        sweep(0, TT_NAND, 1'b1, 1'b0, 1'b1);

        // Second sweep is running; reach vector 2 then reset asynchronously
        repeat (7) @(negedge clk);
        o = get_obs(0);
        chk("pre_reset_vec", 32'(o.vec), 32'd2);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        errm[0] = 0; errm[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("stay_idle");
        end
        sweep(0, TT_NAND, 1'b0, 1'b0, 1'b0);

`ifdef GATE_SWEEP_ERRCNT_EN
        for (int i = 0; i < 256; i++) sweep(0, TT_OR, 1'b0, 1'b0, 1'b0);
        o = get_obs(0);
        chk("err_sat", 32'(o.err), 32'd255);
        sweep(0, TT_NAND, 1'b0, 1'b0, 1'b0);
        o = get_obs(0);
        chk("err_keep", 32'(o.err), 32'd255);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 o = get_obs(0);
        chk("err_clr", 32'(o.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
